dfr_phase_sequencer: RTL

- Sits directly downstream of the AXI configuration register block and consumes its ctrl start bit and the num_* counts.
- Runs a DFR job as three ordered phases, INIT, TRAIN and TEST, and issues one reservoir step request per step through a valid/ready handshake.
- Tags each step with its phase, sample index and step index.
- Drives busy back into ctrl bit 1 of the configuration registers.

---
 rtl/dfr_phase_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/dfr_phase_sequencer.sv
// dfr_phase_sequencer: runs a DFR job as INIT/TRAIN/TEST phases, issuing one tagged reservoir step per valid/ready transfer
module dfr_phase_sequencer #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_init_samples,
  input  logic [CNT_WIDTH-1:0] num_init_steps,
  input  logic [CNT_WIDTH-1:0] num_train_samples,
  input  logic [CNT_WIDTH-1:0] num_train_steps,
  input  logic [CNT_WIDTH-1:0] num_test_samples,
  input  logic [CNT_WIDTH-1:0] num_test_steps,
  input  logic [CNT_WIDTH-1:0] num_steps_per_sample,
  input  logic                 step_ready,
  output logic                 step_valid,
  output logic [1:0]           phase,
  output logic [CNT_WIDTH-1:0] sample_idx,
  output logic [CNT_WIDTH-1:0] step_idx,
  output logic                 last_step_of_sample,
  output logic                 busy,
  output logic                 done,
  output logic                 sample_mismatch
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_TRAIN = 3'd2;
  localparam logic [2:0] S_TEST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  logic [2:0]           state;
  logic [CNT_WIDTH-1:0] init_samples_q, init_steps_q, train_samples_q, train_steps_q;
  logic [CNT_WIDTH-1:0] test_samples_q, test_steps_q, sps_m1, step_in_sample;
  logic [CNT_WIDTH-1:0] cur_steps, cur_samples;
  logic [CNT_WIDTH:0]   completed;
  logic                 xfer, phase_end;
  // first phase after 'from' with a nonzero step count, else DONE
  function automatic logic [2:0] next_phase(input logic [2:0] from,
                                            input logic [CNT_WIDTH-1:0] a, b, c);
    return (from < S_INIT  && a != '0) ? S_INIT  :
           (from < S_TRAIN && b != '0) ? S_TRAIN :
           (from < S_TEST  && c != '0) ? S_TEST  : S_DONE;
  endfunction
  assign step_valid          = state == S_INIT || state == S_TRAIN || state == S_TEST;
  assign phase               = step_valid ? state[1:0] : 2'd0;
  assign busy                = state != S_IDLE;
  assign done                = state == S_DONE;
  assign last_step_of_sample = step_valid && step_in_sample == sps_m1;
  assign xfer                = step_valid && step_ready;
  always_comb begin
    cur_steps   = state == S_INIT ? init_steps_q   : state == S_TRAIN ? train_steps_q   : test_steps_q;
    cur_samples = state == S_INIT ? init_samples_q : state == S_TRAIN ? train_samples_q : test_samples_q;
    completed   = {1'b0, sample_idx} + (CNT_WIDTH+1)'(last_step_of_sample);
    phase_end   = step_idx == cur_steps - CNT_WIDTH'(1);
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state           <= S_IDLE;
      init_samples_q  <= '0;
      init_steps_q    <= '0;
      train_samples_q <= '0;
      train_steps_q   <= '0;
      test_samples_q  <= '0;
      test_steps_q    <= '0;
      sps_m1          <= '0;
      step_in_sample  <= '0;
      sample_idx      <= '0;
      step_idx        <= '0;
      sample_mismatch <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          init_samples_q  <= num_init_samples;
          init_steps_q    <= num_init_steps;
          train_samples_q <= num_train_samples;
          train_steps_q   <= num_train_steps;
          test_samples_q  <= num_test_samples;
          test_steps_q    <= num_test_steps;
          sps_m1          <= num_steps_per_sample == '0 ? '0 : num_steps_per_sample - CNT_WIDTH'(1);
          sample_mismatch <= 1'b0;
          state           <= next_phase(S_IDLE, num_init_steps, num_train_steps, num_test_steps);
        end
        S_INIT, S_TRAIN, S_TEST: if (xfer) begin
          if (phase_end) begin
            if (completed != {1'b0, cur_samples} || !last_step_of_sample) sample_mismatch <= 1'b1;
            step_idx       <= '0;
            sample_idx     <= '0;
            step_in_sample <= '0;
            state          <= next_phase(state, init_steps_q, train_steps_q, test_steps_q);
          end else begin
            step_idx       <= step_idx + CNT_WIDTH'(1);
            step_in_sample <= last_step_of_sample ? '0 : step_in_sample + CNT_WIDTH'(1);
            sample_idx     <= last_step_of_sample ? sample_idx + CNT_WIDTH'(1) : sample_idx;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
